// File: rtl/life_board_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : life_board_scanner
//  Brief    : Freezes a Game of Life board snapshot and streams it row-major
//             over valid/ready with coordinates and end-of-row/frame markers.
//             Define LIFE_SCAN_POPCOUNT_EN to build the frame population counter.
//  Revision : 1.0  initial release
// ============================================================================
module life_board_scanner #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    localparam int c_COL_W = $clog2(WIDTH),
    localparam int c_ROW_W = $clog2(HEIGHT),
    localparam int c_POP_W = $clog2(WIDTH*HEIGHT+1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH*HEIGHT-1:0]   board,
    input  logic                      snap_req,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_bit,
    output logic [c_COL_W-1:0]        out_col,
    output logic [c_ROW_W-1:0]        out_row,
    output logic                      out_eol,
    output logic                      out_eof,
    output logic                      pop_valid,
    output logic [c_POP_W-1:0]        pop_count
);

    localparam logic [0:0]         c_ST_IDLE  = 1'b0;
    localparam logic [0:0]         c_ST_SCAN  = 1'b1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(WIDTH-1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(HEIGHT-1);

    logic [0:0]              r_state;
    logic                    r_valid;
    logic [WIDTH*HEIGHT-1:0] r_snap;
    logic [c_COL_W-1:0]      r_col;
    logic [c_ROW_W-1:0]      r_row;
    logic                    r_eol;
    logic                    r_eof;
    logic                    w_xfer;
    logic                    w_capture;
    logic [c_COL_W-1:0]      w_col_inc;

    assign w_xfer    = r_valid & out_ready;
    assign w_capture = (r_state == c_ST_IDLE) & snap_req;
    assign w_col_inc = r_col + c_COL_W'(1);

    // The snapshot shifts right on each transfer, so bit 0 is always the presented cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_valid <= 1'b0;
            r_snap  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (snap_req) begin
                        r_state <= c_ST_SCAN;
                        r_valid <= 1'b1;
                        r_snap  <= board;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_eol   <= 1'b0;
                        r_eof   <= 1'b0;
                    end
                end
                c_ST_SCAN: begin
                    if (out_ready) begin
                        r_snap <= r_snap >> 1;
                        if (r_eof) begin
                            r_state <= c_ST_IDLE;
                            r_valid <= 1'b0;
                            r_col   <= '0;
                            r_row   <= '0;
                            r_eol   <= 1'b0;
                            r_eof   <= 1'b0;
                        end else if (r_eol) begin
                            r_col <= '0;
                            r_row <= r_row + c_ROW_W'(1);
                            r_eol <= 1'b0;
                            r_eof <= 1'b0;
                        end else begin
                            r_col <= w_col_inc;
                            r_eol <= (w_col_inc == c_COL_LAST);
                            r_eof <= (w_col_inc == c_COL_LAST) && (r_row == c_ROW_LAST);
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_valid;
    assign out_valid = r_valid;
    assign out_bit   = r_snap[0];
    assign out_col   = r_col;
    assign out_row   = r_row;
    assign out_eol   = r_eol;
    assign out_eof   = r_eof;

`ifdef LIFE_SCAN_POPCOUNT_EN
    logic               r_pop_valid;
    logic [c_POP_W-1:0] r_pop_count;

    // The accumulator doubles as the held result once the frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pop_valid <= 1'b0;
            r_pop_count <= '0;
        end else begin
            r_pop_valid <= w_xfer & r_eof;
            if (w_capture) begin
                r_pop_count <= '0;
            end else if (w_xfer) begin
                r_pop_count <= r_pop_count + c_POP_W'(r_snap[0]);
            end
        end
    end

    assign pop_valid = r_pop_valid;
    assign pop_count = r_pop_count;
`else
    assign pop_valid = 1'b0;
    assign pop_count = '0;
`endif

endmodule
`default_nettype wire
